// File: rtl/ram_r_ctrl_pkg.sv
// Shared sizing and FSM encoding for the OMP R-matrix RAM controller.
package ram_r_ctrl_pkg;
  localparam int RAM_DATA_W   = 19;
  localparam int RAM_ADDR_W   = 6;
  localparam int RAM_MEM_SIZE = 64;
  localparam int ROWS         = 8;
  localparam int COLS         = 8;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_LATCH,
    ST_RD_RESP
  } state_e;
endpackage

// File: rtl/ram_r_rr_arb.sv
// Two-requester round-robin arbiter; the preference pointer flips only when both request.
module ram_r_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic wr_req,
  input  logic rd_req,
  output logic wr_gnt,
  output logic rd_gnt
);
  logic rd_first_q, rd_first_d;

  always_comb begin
    rd_gnt     = en && rd_req && (!wr_req || rd_first_q);
    wr_gnt     = en && wr_req && (!rd_req || !rd_first_q);
    rd_first_d = (en && wr_req && rd_req) ? !rd_first_q : rd_first_q;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_first_q <= 1'b1;
    else     rd_first_q <= rd_first_d;
  end
endmodule

// File: rtl/ram_r_ctrl.sv
// R-matrix RAM front-end: word writes, registered 8-word row reads, round-robin sharing.
// Optional zero-fill after reset / on clr_req is enabled by defining RAM_R_CTRL_INIT_EN.
module ram_r_ctrl
  import ram_r_ctrl_pkg::*;
#(
  parameter int DATA_W   = RAM_DATA_W,
  parameter int ADDR_W   = RAM_ADDR_W,
  parameter int MEM_SIZE = RAM_MEM_SIZE
) (
  input  logic                CK,
  input  logic                RST,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_valid,
  output logic                rd_ready,
  input  logic [2:0]          rd_row,
  output logic                rd_data_valid,
  input  logic                rd_data_ready,
  output logic [8*DATA_W-1:0] rd_data,
  input  logic                clr_req,
  output logic                init_busy,
  output logic [ADDR_W-1:0]   ram_A,
  output logic                ram_WE,
  output logic                ram_OE,
  output logic [DATA_W-1:0]   ram_D,
  input  logic [8*DATA_W-1:0] ram_Q
);
`ifdef RAM_R_CTRL_INIT_EN
  localparam state_e RESET_STATE = ST_INIT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);
  logic [ADDR_W-1:0] cnt_q, cnt_d;
`else
  localparam state_e RESET_STATE = ST_IDLE;
`endif

  state_e              state_q, state_d;
  logic [2:0]          row_q, row_d;
  logic [8*DATA_W-1:0] rd_data_q, rd_data_d;
  logic                rd_vld_q, rd_vld_d;
  logic                arb_en, gnt_wr, gnt_rd;

`ifdef RAM_R_CTRL_INIT_EN
  assign arb_en    = !RST && (state_q == ST_IDLE) && !clr_req;
  assign init_busy = (state_q == ST_INIT);
`else
  logic unused_clr;
  assign unused_clr = clr_req;
  assign arb_en     = !RST && (state_q == ST_IDLE);
  assign init_busy  = 1'b0;
`endif

  ram_r_rr_arb u_arb (
    .clk    (CK),
    .rst    (RST),
    .en     (arb_en),
    .wr_req (wr_valid),
    .rd_req (rd_valid),
    .wr_gnt (gnt_wr),
    .rd_gnt (gnt_rd)
  );

  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_vld_q;

  // RAM strobes are held at their reset values while RST is asserted.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    rd_data_d = rd_data_q;
    rd_vld_d  = rd_vld_q;
`ifdef RAM_R_CTRL_INIT_EN
    cnt_d     = cnt_q;
`endif
    ram_A     = '0;
    ram_WE    = 1'b0;
    ram_OE    = 1'b0;
    ram_D     = '0;
    wr_ready  = 1'b0;
    rd_ready  = 1'b0;
    if (!RST) begin
      case (state_q)
`ifdef RAM_R_CTRL_INIT_EN
        ST_INIT: begin
          ram_A  = cnt_q;
          ram_WE = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
`endif
        ST_IDLE: begin
`ifdef RAM_R_CTRL_INIT_EN
          if (clr_req) begin
            cnt_d   = '0;
            state_d = ST_INIT;
          end
`endif
          wr_ready = gnt_wr;
          rd_ready = gnt_rd;
          if (gnt_wr) begin
            ram_A  = wr_addr;
            ram_WE = 1'b1;
            ram_D  = wr_data;
          end else if (gnt_rd) begin
            ram_A   = {{(ADDR_W-3){1'b0}}, rd_row};
            ram_OE  = 1'b1;
            row_d   = rd_row;
            state_d = ST_RD_LATCH;
          end
        end
        ST_RD_LATCH: begin
          ram_A     = {{(ADDR_W-3){1'b0}}, row_q};
          ram_OE    = 1'b1;
          rd_data_d = ram_Q;
          rd_vld_d  = 1'b1;
          state_d   = ST_RD_RESP;
        end
        ST_RD_RESP: begin
          if (rd_data_ready) begin
            rd_vld_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q   <= RESET_STATE;
      row_q     <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
`ifdef RAM_R_CTRL_INIT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
`ifdef RAM_R_CTRL_INIT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_ram_r_ctrl.sv
// Directed bench for ram_r_ctrl with a row-organised RAM model behind it.
module tb_ram_r_ctrl;
  import ram_r_ctrl_pkg::*;
  localparam int DATA_W = RAM_DATA_W;
  localparam int ADDR_W = RAM_ADDR_W;
  localparam int MEMSZ  = RAM_MEM_SIZE;
  localparam int RW     = 8 * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid, wr_ready, rd_valid, rd_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [2:0]        rd_row;
  logic              rd_data_valid, rd_data_ready;
  logic [RW-1:0]     rd_data;
  logic              clr_req, init_busy;
  logic [ADDR_W-1:0] ram_A;
  logic              ram_WE, ram_OE;
  logic [DATA_W-1:0] ram_D;
  logic [RW-1:0]     ram_Q;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ram_r_ctrl dut (
    .CK(clk), .RST(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_row(rd_row),
    .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .rd_data(rd_data),
    .clr_req(clr_req), .init_busy(init_busy),
    .ram_A(ram_A), .ram_WE(ram_WE), .ram_OE(ram_OE), .ram_D(ram_D), .ram_Q(ram_Q)
  );

  // RAM model: word writes, address latched every edge, row = latched A[2:0].
  logic [DATA_W-1:0] mem [MEMSZ];
  logic [ADDR_W-1:0] a_lat = '0;
  always @(posedge clk) begin
    if (ram_WE) mem[ram_A] <= ram_D;
    a_lat <= ram_A;
  end
  always_comb begin
    ram_Q = '0;
    for (int i = 0; i < 8; i++) ram_Q[DATA_W*i +: DATA_W] = mem[{a_lat[2:0], 3'(i)}];
  end

  task automatic chk(input string tag, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    chk("wr_ready", RW'(wr_ready), RW'(1));
    chk("wr_ram", RW'({ram_WE, ram_OE, ram_A, ram_D}), RW'({1'b1, 1'b0, a, d}));
    cyc();
    wr_valid = 1'b0;
  endtask

  // Issue a row read, hold the response for 'hold' cycles, then consume it.
  task automatic do_read(input logic [2:0] row, input int hold, output logic [RW-1:0] data);
    int lat;
    rd_valid = 1'b1; rd_row = row; rd_data_ready = 1'b0;
    @(negedge clk);
    chk("rd_ready", RW'(rd_ready), RW'(1));
    chk("rd_ram", RW'({ram_WE, ram_OE, ram_A}), RW'({1'b0, 1'b1, 3'b000, row}));
    cyc();
    rd_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rd_data_valid && lat < 8) begin
      cyc(); lat++; @(negedge clk);
    end
    chk("rd_latency", RW'(lat), RW'(2));
    data = rd_data;
    for (int k = 0; k < hold; k++) begin
      cyc();
      wr_valid = 1'b1; rd_valid = 1'b1;
      @(negedge clk);
      chk("stall_vld", RW'(rd_data_valid), RW'(1));
      chk("stall_data", rd_data, data);
      chk("stall_quiet", RW'({ram_WE, ram_OE, wr_ready, rd_ready}), RW'(0));
    end
    cyc();
    wr_valid = 1'b0; rd_valid = 1'b0; rd_data_ready = 1'b1;
    @(negedge clk);
    chk("rd_vld_hs", RW'(rd_data_valid), RW'(1));
    cyc();
    rd_data_ready = 1'b0;
    @(negedge clk);
    chk("rd_vld_drop", RW'(rd_data_valid), RW'(0));
    cyc();
  endtask

  logic [RW-1:0] got, exp_row;
  logic [5:0]    g_rd, g_wr;
  int            e;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
`ifdef RAM_R_CTRL_INIT_EN
    for (int i = 0; i < MEMSZ; i++) mem[i] = '1;
`else
    for (int i = 0; i < MEMSZ; i++) mem[i] = '0;
`endif
    rst = 1'b1; clr_req = 1'b0; rd_data_ready = 1'b0;
    wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 6'd9; wr_data = 19'h1234; rd_row = 3'd4;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_ram", RW'({ram_WE, ram_OE, ram_A, ram_D}), RW'(0));
    chk("rst_grants", RW'({wr_ready, rd_ready}), RW'(0));
    chk("rst_rd_vld", RW'(rd_data_valid), RW'(0));
    chk("rst_rd_data", rd_data, RW'(0));
    cyc();
    rst = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;

`ifdef RAM_R_CTRL_INIT_EN
    wr_valid = 1'b1;
    e = 0;
    for (int k = 0; k < MEMSZ; k++) begin
      @(negedge clk);
      if (!init_busy || !ram_WE || ram_OE || ram_A != ADDR_W'(k) || ram_D != '0 || wr_ready) e++;
      cyc();
    end
    wr_valid = 1'b0;
    chk("init_seq_errs", RW'(e), RW'(0));
    @(negedge clk);
    chk("init_done", RW'(init_busy), RW'(0));
    cyc();
`else
    @(negedge clk);
    chk("init_busy_tied", RW'(init_busy), RW'(0));
    cyc();
`endif

    do_read(3'd5, 0, got);
    chk("row5_zero", got, RW'(0));

    for (int c = 0; c < 8; c++) do_write(ADDR_W'(8 + c), DATA_W'(32'h100 + c));
    exp_row = '0;
    for (int i = 0; i < 8; i++) exp_row[DATA_W*i +: DATA_W] = DATA_W'(32'h100 + i);
    do_read(3'd1, 0, got);
    chk("row1_data", got, exp_row);

    // Contention: read-first pointer, toggles on each contested grant.
    wr_valid = 1'b1; wr_addr = 6'd20; wr_data = 19'h333;
    rd_valid = 1'b1; rd_row = 3'd3; rd_data_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      g_rd[c] = rd_ready; g_wr[c] = wr_ready;
      cyc();
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    cyc(); cyc();
    rd_data_ready = 1'b0;
    chk("rr_rd_grants", RW'(g_rd), RW'(6'b010001));
    chk("rr_wr_grants", RW'(g_wr), RW'(6'b001000));

    do_read(3'd1, 5, got);
    chk("row1_stall", got, exp_row);

    do_write(6'd17, 19'h5A5A);
    do_read(3'd2, 0, got);
    exp_row = '0;
    exp_row[DATA_W*1 +: DATA_W] = 19'h5A5A;
    exp_row[DATA_W*4 +: DATA_W] = 19'h333;
    chk("row2_fwd", got, exp_row);

    // Reset while the controller sits in RD_LATCH.
    rd_valid = 1'b1; rd_row = 3'd1;
    cyc();
    rd_valid = 1'b0; rst = 1'b1;
    cyc();
    @(negedge clk);
    chk("rstmid_vld", RW'(rd_data_valid), RW'(0));
    chk("rstmid_oe", RW'(ram_OE), RW'(0));
    chk("rstmid_data", rd_data, RW'(0));
    cyc();
    rst = 1'b0;
    @(negedge clk);
`ifdef RAM_R_CTRL_INIT_EN
    chk("rstmid_state", RW'(init_busy), RW'(1));
`else
    chk("rstmid_state", RW'({init_busy, ram_WE, ram_OE}), RW'(0));
`endif
    e = 0;
    for (int k = 0; k < 70; k++) begin
      cyc(); @(negedge clk);
      if (rd_data_valid) e++;
    end
    chk("rstmid_no_stale", RW'(e), RW'(0));
    cyc();

`ifdef RAM_R_CTRL_INIT_EN
    clr_req = 1'b1; wr_valid = 1'b1; wr_addr = 6'd3; wr_data = 19'h777;
    @(negedge clk);
    chk("clr_prio", RW'({wr_ready, ram_WE}), RW'(0));
    cyc();
    clr_req = 1'b0; wr_valid = 1'b0;
    e = 0;
    @(negedge clk);
    while (init_busy && e < 100) begin
      cyc(); e++; @(negedge clk);
    end
    chk("clr_len", RW'(e), RW'(64));
    cyc();
    do_read(3'd1, 0, got);
    chk("clr_row1_zero", got, RW'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
